// File: rtl/stopwatch_bcd_core_if.sv
// Signal bundle between the stopwatch core and its neighbours: the run
// switch and clear going in, packed BCD digits and status flags coming out.
interface stopwatch_bcd_core_if;
  logic        SW_in;
  logic        CLR_in;
  logic [15:0] bcd_out;
  logic        tick_out;
  logic        run_out;
  logic        ovf_out;

  // Driver side: owns the switch and clear, observes the count.
  modport master (
    output SW_in,
    output CLR_in,
    input  bcd_out,
    input  tick_out,
    input  run_out,
    input  ovf_out
  );

  // Core side.
  modport slave (
    input  SW_in,
    input  CLR_in,
    output bcd_out,
    output tick_out,
    output run_out,
    output ovf_out
  );
endinterface

// File: rtl/stopwatch_bcd_core.sv
// Four-digit BCD stopwatch core: synchronises and debounces the run switch,
// divides the clock down to a count tick, and advances a 0000-9999 BCD
// count with a sticky wrap flag. Clear zeroes the count path only.
module stopwatch_bcd_core #(
  parameter int TICK_DIV   = 500000,
  parameter int DEB_CYCLES = 1000000
) (
  input logic                 CLK,
  input logic                 RST_N,
  stopwatch_bcd_core_if.slave bus
);

  localparam int PCNT_W = 19;
  localparam int DCNT_W = 20;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(TICK_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_PEND_H = 2'd1,
    S_HIGH   = 2'd2,
    S_PEND_L = 2'd3
  } deb_state_e;

  logic              r_sw_s1;
  logic              r_sw_s2;
  deb_state_e        r_state;
  deb_state_e        w_state_nxt;
  logic [DCNT_W-1:0] r_dcnt;
  logic [DCNT_W-1:0] w_dcnt_nxt;
  logic              w_run;

  logic [PCNT_W-1:0] r_pcnt;
  logic              w_advance;
  logic              w_tick;

  logic [15:0]       r_bcd;
  logic [15:0]       w_bcd_inc;
  logic              w_carry;
  logic              r_tick;
  logic              r_ovf;

  // Two-flop synchroniser for the asynchronous switch.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: every clocked block uses non-blocking assignments so that all
    // registers sample pre-edge values; blocking here would collapse the
    // two synchroniser stages into one.
    if (!RST_N) begin
      r_sw_s1 <= 1'b0;
      r_sw_s2 <= 1'b0;
    end else begin
      r_sw_s1 <= bus.SW_in;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // Debounce FSM state and qualification counter register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_LOW;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  // Debounce next state: a new level must hold for DEB_CYCLES cycles; any
  // return to the old level restarts qualification from zero.
  always_comb begin
    // NOTE: defaults first so every path assigns every output of this
    // block; a missing branch would otherwise infer a latch.
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    unique case (r_state)
      S_LOW: begin
        if (r_sw_s2) begin
          w_state_nxt = S_PEND_H;
          w_dcnt_nxt  = '0;
        end
      end
      S_PEND_H: begin
        if (!r_sw_s2) begin
          w_state_nxt = S_LOW;
          w_dcnt_nxt  = '0;
        end else if (r_dcnt == DCNT_MAX) begin
          w_state_nxt = S_HIGH;
          w_dcnt_nxt  = '0;
        end else begin
          w_dcnt_nxt  = r_dcnt + DCNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!r_sw_s2) begin
          w_state_nxt = S_PEND_L;
          w_dcnt_nxt  = '0;
        end
      end
      S_PEND_L: begin
        if (r_sw_s2) begin
          w_state_nxt = S_HIGH;
          w_dcnt_nxt  = '0;
        end else if (r_dcnt == DCNT_MAX) begin
          w_state_nxt = S_LOW;
          w_dcnt_nxt  = '0;
        end else begin
          w_dcnt_nxt  = r_dcnt + DCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_dcnt_nxt  = '0;
      end
    endcase
  end

  // Debounce output: the accepted level is a decode of the registered state.
  always_comb begin
    w_run = (r_state == S_HIGH) || (r_state == S_PEND_L);
  end

  assign w_advance = w_run && !bus.CLR_in;
  assign w_tick    = w_advance && (r_pcnt == PCNT_MAX);

  // Prescaler: holds while paused so a resume finishes the partial period.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pcnt <= '0;
    end else if (bus.CLR_in) begin
      r_pcnt <= '0;
    end else if (w_advance) begin
      r_pcnt <= w_tick ? '0 : r_pcnt + PCNT_W'(1);
    end
  end

  // Ripple BCD increment; w_carry left set means 9999 rolled to 0000.
  always_comb begin
    w_bcd_inc = r_bcd;
    w_carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_bcd[4*i +: 4] >= 4'd9) begin
          w_bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
    end
  end

  // Count, tick pulse and sticky overflow; clear beats a coinciding tick.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bcd  <= 16'h0000;
      r_tick <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.CLR_in) begin
      r_bcd  <= 16'h0000;
      r_tick <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (w_tick) begin
        r_bcd <= w_bcd_inc;
        if (w_carry) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign bus.bcd_out  = r_bcd;
  assign bus.tick_out = r_tick;
  assign bus.run_out  = w_run;
  assign bus.ovf_out  = r_ovf;

endmodule
